bcd_serial_adder: RTL and testbench

- Digit-serial, multi-digit packed-BCD adder; parametrised successor of the single-digit combinational BCD adder.
- Processes one BCD digit per clock, least significant digit first, under a start/busy/done handshake.
- Holds its result until the next operation.
- Used wherever wide decimal arithmetic is needed without a DIGITS-deep combinational carry chain.

---
 rtl/bcd_serial_adder.sv | 170 +++++++++++++++++
 tb/tb_bcd_serial_adder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_adder.sv
// bcd_serial_adder: digit-serial packed-BCD adder, one digit per clock, LSD first.
// A start/busy/done handshake frames each operation; results hold until the next start.
// Optional subtraction (nine's complement of b) is compiled in with `define BCD_SUB_EN.
module bcd_serial_adder #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
`ifdef BCD_SUB_EN
  input  logic                  sub,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  z,
  output logic                  invalid
);

  localparam int W    = 4 * DIGITS;
  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  // True when any 4-bit digit of v holds a non-decimal code (A..F).
  function automatic logic has_non_bcd(input logic [W-1:0] v);
    logic f;
    f = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      f = f | (v[4*i +: 4] > 4'd9);
    end
    return f;
  endfunction

  logic [0:0]      r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_carry;
  logic [IDXW-1:0] r_idx;
  logic [W-1:0]    r_sum;
  logic            r_busy;
  logic            r_done;
  logic            r_cout;
  logic            r_z;
  logic            r_invalid;
`ifdef BCD_SUB_EN
  logic            r_sub;
`endif

  logic [3:0]      w_a_dig;
  logic [3:0]      w_b_dig;
  logic [3:0]      w_b_eff;
  logic [4:0]      w_t;
  logic [4:0]      w_t_m10;
  logic [3:0]      w_digit;
  logic            w_carry_next;
  logic            w_cout_final;
  logic            w_init_carry;
  logic            w_last;
  logic [W-1:0]    w_sum_next;

  // Digit datapath: select digit r_idx, form the 5-bit sum and decimal-adjust it.
  always_comb begin
    w_a_dig    = 4'd0;
    w_b_dig    = 4'd0;
    w_sum_next = r_sum;
    for (int i = 0; i < DIGITS; i++) begin
      w_a_dig = w_a_dig | ((r_idx == IDXW'(i)) ? r_a[4*i +: 4] : 4'd0);
      w_b_dig = w_b_dig | ((r_idx == IDXW'(i)) ? r_b[4*i +: 4] : 4'd0);
    end
`ifdef BCD_SUB_EN
    w_b_eff      = r_sub ? (4'd9 - w_b_dig) : w_b_dig;
    w_init_carry = sub ? ~cin : cin;
`else
    w_b_eff      = w_b_dig;
    w_init_carry = cin;
`endif
    // Kept 5 bits wide: 9+9+1 = 19 must not wrap before the >9 test.
    w_t     = {1'b0, w_a_dig} + {1'b0, w_b_eff} + {4'd0, r_carry};
    w_t_m10 = w_t - 5'd10;
    if (w_t > 5'd9) begin
      w_digit      = w_t_m10[3:0];
      w_carry_next = 1'b1;
    end else begin
      w_digit      = w_t[3:0];
      w_carry_next = 1'b0;
    end
    for (int i = 0; i < DIGITS; i++) begin
      w_sum_next[4*i +: 4] = (r_idx == IDXW'(i)) ? w_digit : r_sum[4*i +: 4];
    end
`ifdef BCD_SUB_EN
    // A missing final carry in nine's-complement subtraction means a borrow.
    w_cout_final = r_sub ? ~w_carry_next : w_carry_next;
`else
    w_cout_final = w_carry_next;
`endif
    w_last = (r_idx == IDXW'(DIGITS - 1));
  end

  // Control FSM and result registers: latch on start, one digit per RUN cycle, flag on the last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_a       <= {W{1'b0}};
      r_b       <= {W{1'b0}};
      r_carry   <= 1'b0;
      r_idx     <= {IDXW{1'b0}};
      r_sum     <= {W{1'b0}};
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_cout    <= 1'b0;
      r_z       <= 1'b1;
      r_invalid <= 1'b0;
`ifdef BCD_SUB_EN
      r_sub     <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= w_init_carry;
            r_idx   <= {IDXW{1'b0}};
            r_sum   <= {W{1'b0}};
            r_busy  <= 1'b1;
            r_state <= S_RUN;
`ifdef BCD_SUB_EN
            r_sub   <= sub;
`endif
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_sum   <= w_sum_next;
          r_carry <= w_carry_next;
          if (w_last) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_cout    <= w_cout_final;
            r_z       <= (w_sum_next == {W{1'b0}});
            r_invalid <= has_non_bcd(r_a) | has_non_bcd(r_b);
            r_state   <= S_IDLE;
          end else begin
            r_idx <= r_idx + IDXW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign sum     = r_sum;
  assign cout    = r_cout;
  assign z       = r_z;
  assign invalid = r_invalid;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// tb_bcd_serial_adder: scoreboard bench for bcd_serial_adder (DIGITS=4).
// Expected results are pushed when start is driven and popped when done pulses.
module tb_bcd_serial_adder;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         zz;
    logic         inv;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef BCD_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         z;
  logic         invalid;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  exp_t sb[$];
  exp_t dropped;

  bcd_serial_adder #(.DIGITS(DIGITS)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .a(a),
    .b(b),
    .cin(cin),
`ifdef BCD_SUB_EN
    .sub(sub),
`endif
    .busy(busy),
    .done(done),
    .sum(sum),
    .cout(cout),
    .z(z),
    .invalid(invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal digit-by-digit addition (or nine's-complement subtraction).
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic ci, input logic sb_v);
    exp_t r;
    logic c;
    logic [3:0] ad, bd;
    int t;
    r.s   = '0;
    r.inv = 1'b0;
    c = sb_v ? ~ci : ci;
    for (int i = 0; i < DIGITS; i++) begin
      ad = av[4*i +: 4];
      bd = bv[4*i +: 4];
      if (ad > 4'd9 || bd > 4'd9) r.inv = 1'b1;
      if (sb_v) bd = 4'd9 - bd;
      t = int'(ad) + int'(bd) + int'(c);
      if (t > 9) begin
        r.s[4*i +: 4] = 4'((t - 10) % 16);
        c = 1'b1;
      end else begin
        r.s[4*i +: 4] = 4'(t);
        c = 1'b0;
      end
    end
    r.c  = sb_v ? ~c : c;
    r.zz = (r.s == '0);
    return r;
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] v;
    for (int i = 0; i < DIGITS; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  // Scoreboard consumer: compare every done pulse against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check_val("sb_unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_val("mon_sum", 32'(sum), 32'(e.s));
        check_val("mon_cout", 32'(cout), 32'(e.c));
        check_val("mon_z", 32'(z), 32'(e.zz));
        check_val("mon_invalid", 32'(invalid), 32'(e.inv));
        check_val("mon_busy_low", 32'(busy), 32'd0);
      end
    end
  end

  // Drive a start request at the current negedge and record its expected result.
  task automatic op_start(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic ci, input logic sb_v);
    a     = av;
    b     = bv;
    cin   = ci;
`ifdef BCD_SUB_EN
    sub   = sb_v;
`endif
    start = 1'b1;
    sb.push_back(model(av, bv, ci, sb_v));
  endtask

  // Wait (bounded) for done; optionally keep start high with junk operands while busy.
  task automatic wait_done(input bit hold);
    int cyc = 0;
    int bc  = 0;
    bit seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check_val("sum_clear", 32'(sum), 32'd0);
      if (busy) bc++;
      if (done) seen = 1'b1;
      if (hold && !seen) begin
        start = 1'b1;
        a     = W'($urandom);
        b     = W'($urandom);
        cin   = 1'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    check_val("done_seen", 32'(seen), 32'd1);
    check_val("latency", 32'(cyc), 32'(DIGITS + 1));
    check_val("busy_cycles", 32'(bc), 32'(DIGITS));
  endtask

  initial begin
    int dc;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
`ifdef BCD_SUB_EN
    sub   = 1'b0;
`endif
    #12;
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_sum", 32'(sum), 32'd0);
    check_val("rst_z", 32'(z), 32'd1);
    check_val("rst_cout", 32'(cout), 32'd0);
    check_val("rst_invalid", 32'(invalid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic addition and result hold.
    op_start(16'h1234, 16'h5678, 1'b0, 1'b0);
    wait_done(1'b0);
    repeat (3) @(negedge clk);
    check_val("tp1_sum_hold", 32'(sum), 32'h6912);
    check_val("tp1_cout", 32'(cout), 32'd0);
    check_val("tp1_z", 32'(z), 32'd0);

    // Carry ripple through all nines.
    op_start(16'h9999, 16'h0000, 1'b1, 1'b0);
    wait_done(1'b0);
    check_val("tp2_sum", 32'(sum), 32'h0000);
    check_val("tp2_cout", 32'(cout), 32'd1);
    check_val("tp2_z", 32'(z), 32'd1);

    // Non-BCD digit flags invalid; next valid op clears it.
    op_start(16'h12A4, 16'h0001, 1'b0, 1'b0);
    wait_done(1'b0);
    check_val("tp3_invalid", 32'(invalid), 32'd1);
    check_val("tp3_sum", 32'(sum), 32'h1305);
    op_start(16'h0001, 16'h0001, 1'b0, 1'b0);
    wait_done(1'b0);
    check_val("tp3_invalid_clear", 32'(invalid), 32'd0);

    // Start held high during RUN is ignored.
    op_start(16'h2222, 16'h3333, 1'b0, 1'b0);
    wait_done(1'b1);
    check_val("tp4_hold_sum", 32'(sum), 32'h5555);

    // Back-to-back: start during the done cycle.
    op_start(16'h4321, 16'h1111, 1'b1, 1'b0);
    wait_done(1'b0);
    op_start(16'h0099, 16'h0001, 1'b0, 1'b0);
    wait_done(1'b0);
    check_val("tp5_b2b_sum", 32'(sum), 32'h0100);

    // Reset in the middle of an operation.
    op_start(16'h1111, 16'h1111, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    dc = done_cnt;
    rst_n = 1'b0;
    dropped = sb.pop_back();
    #1;
    check_val("mid_rst_busy", 32'(busy), 32'd0);
    check_val("mid_rst_sum", 32'(sum), 32'd0);
    check_val("mid_rst_z", 32'(z), 32'd1);
    check_val("mid_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check_val("mid_rst_no_done", 32'(done_cnt), 32'(dc));
    op_start(16'h0456, 16'h0544, 1'b0, 1'b0);
    wait_done(1'b0);
    check_val("post_rst_sum", 32'(sum), 32'h1000);

    // Random valid BCD operands.
    for (int k = 0; k < 6; k++) begin
      op_start(rand_bcd(), rand_bcd(), 1'($urandom_range(0, 1)), 1'b0);
      wait_done(1'b0);
    end

`ifdef BCD_SUB_EN
    op_start(16'h1000, 16'h0001, 1'b0, 1'b1);
    wait_done(1'b0);
    check_val("sub1_sum", 32'(sum), 32'h0999);
    check_val("sub1_cout", 32'(cout), 32'd0);
    op_start(16'h0000, 16'h0001, 1'b0, 1'b1);
    wait_done(1'b0);
    check_val("sub2_sum", 32'(sum), 32'h9999);
    check_val("sub2_cout", 32'(cout), 32'd1);
    op_start(16'h0500, 16'h0499, 1'b1, 1'b1);
    wait_done(1'b0);
    check_val("sub3_sum", 32'(sum), 32'h0000);
    check_val("sub3_z", 32'(z), 32'd1);
    check_val("sub3_cout", 32'(cout), 32'd0);
`endif

    repeat (2) @(negedge clk);
    check_val("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
